// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared FSM state types and default bit timing for the UART bridge
package uart_bridge_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 serializer, LSB first; start is ignored while a byte is in flight
module uart_tx_serializer
    import uart_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    tx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    shift_d = data;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_ui_bridge.sv
// rtl/uart_ui_bridge.sv - UART 8N1 receiver driving ui_in; optional echo of uo_out when UART_ECHO_EN is defined
module uart_ui_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic [7:0] uo_sample,
    output logic [7:0] ui_drive,
    output logic       ui_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    ui_drive_q, ui_drive_d;
    logic          ui_valid_q, ui_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], uart_rx};
        prev_d      = rx_s;
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ui_drive_d  = ui_drive_q;
        ui_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        ui_drive_d = shift_q;
                        ui_valid_d = 1'b1;
                        state_d    = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                // Any low sample restarts the full-bit high window.
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ui_drive_q  <= 8'h00;
            ui_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ui_drive_q  <= ui_drive_d;
            ui_valid_q  <= ui_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ui_drive  = ui_drive_q;
    assign ui_valid  = ui_valid_q;
    assign frame_err = frame_err_q;

`ifdef UART_ECHO_EN
    // One cycle of delay gives the downstream design time to react to the new ui_in.
    logic echo_go_q, echo_go_d;

    always_comb echo_go_d = ui_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) echo_go_q <= 1'b0;
        else        echo_go_q <= echo_go_d;
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(echo_go_q),
        .data (uo_sample),
        .tx   (uart_tx)
    );
`else
    logic unused_uo_sample;
    assign unused_uo_sample = ^uo_sample;
    assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_ui_bridge.sv
// tb/tb_uart_ui_bridge.sv - directed self-checking bench for uart_ui_bridge
module tb_uart_ui_bridge;

    localparam int CPB = 434;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] uo_sample;
    logic [7:0] ui_drive;
    logic       ui_valid;
    logic       frame_err;

    int n_chk;
    int n_fail;
    int cyc;
    int valid_cnt;
    int valid_cyc;
    int ferr_cnt;
    int both_cnt;
    int tx_low_cnt;
    int last_start;
    int echo_cnt;
    logic [7:0] echo_byte;

    uart_ui_bridge #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .uo_sample(uo_sample),
        .ui_drive (ui_drive),
        .ui_valid (ui_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ui_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (ui_valid && frame_err) both_cnt <= both_cnt + 1;
        if (!uart_tx) tx_low_cnt <= tx_low_cnt + 1;
    end

`ifdef UART_ECHO_EN
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            echo_byte = b;
            echo_cnt  = echo_cnt + 1;
        end
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int stop_len);
        @(posedge clk);
        #1;
        last_start = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(data[i], CPB);
        hold(stop, stop_len);
        uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int v0, f0, e0;
        n_chk = 0; n_fail = 0; cyc = 0;
        valid_cnt = 0; valid_cyc = 0; ferr_cnt = 0; both_cnt = 0; tx_low_cnt = 0;
        last_start = 0; echo_cnt = 0; echo_byte = 8'h00;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        uo_sample = 8'h5A;

        repeat (4) @(negedge clk);
        chk("reset_ui_drive", ui_drive, 8'h00);
        chk("reset_ui_valid", ui_valid, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_uart_tx", uart_tx, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle(10000);
        chk("idle_ui_drive", ui_drive, 8'h00);
        chk("idle_valid_cnt", valid_cnt, 0);
        chk("idle_ferr_cnt", ferr_cnt, 0);
        chk("idle_tx_low", tx_low_cnt, 0);

        send_frame(8'hA5, 1'b1, CPB);
        idle(2 * CPB);
        chk("a5_ui_drive", ui_drive, 8'hA5);
        chk("a5_valid_cnt", valid_cnt, 1);
        chk("a5_ferr_cnt", ferr_cnt, 0);
        chk("a5_latency", valid_cyc - last_start, 3 + CPB / 2 + 9 * CPB);

        v0 = valid_cnt;
        send_frame(8'h3C, 1'b0, CPB);
        idle(2 * CPB);
        chk("bad_stop_ferr_cnt", ferr_cnt, 1);
        chk("bad_stop_ui_drive", ui_drive, 8'hA5);
        chk("bad_stop_no_valid", valid_cnt, v0);
        send_frame(8'h81, 1'b1, CPB);
        idle(2 * CPB);
        chk("after_err_ui_drive", ui_drive, 8'h81);
        chk("after_err_valid", valid_cnt, v0 + 1);

        v0 = valid_cnt;
        f0 = ferr_cnt;
        hold(1'b0, 100);
        idle(2 * CPB);
        chk("glitch_no_valid", valid_cnt, v0);
        chk("glitch_no_ferr", ferr_cnt, f0);
        send_frame(8'h42, 1'b1, CPB);
        idle(2 * CPB);
        chk("post_glitch_ui_drive", ui_drive, 8'h42);

        v0 = valid_cnt;
        send_frame(8'h12, 1'b1, CPB / 2 + 20);
        send_frame(8'h34, 1'b1, CPB);
        idle(2 * CPB);
        chk("b2b_valid_cnt", valid_cnt, v0 + 2);
        chk("b2b_ui_drive", ui_drive, 8'h34);

        v0 = valid_cnt;
        f0 = ferr_cnt;
        fork
            send_frame(8'hC3, 1'b1, CPB);
            begin
                repeat (5 * CPB + CPB / 2) @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("midrst_ui_drive", ui_drive, 8'h00);
                chk("midrst_uart_tx", uart_tx, 1'b1);
                repeat (2 * CPB - 3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        idle(2 * CPB);
        chk("abort_no_valid", valid_cnt, v0);
        chk("abort_no_ferr", ferr_cnt, f0);
        chk("abort_ui_drive", ui_drive, 8'h00);
        send_frame(8'hFF, 1'b1, CPB);
        idle(2 * CPB);
        chk("post_rst_ui_drive", ui_drive, 8'hFF);

`ifdef UART_ECHO_EN
        idle(12 * CPB);
        e0 = echo_cnt;
        send_frame(8'h01, 1'b1, CPB / 2 + 20);
        send_frame(8'h02, 1'b1, CPB);
        idle(12 * CPB);
        chk("echo_count", echo_cnt - e0, 1);
        chk("echo_byte", echo_byte, 8'h5A);
        chk("echo_rx_ui_drive", ui_drive, 8'h02);
`else
        e0 = 0;
        chk("no_echo_tx_low", tx_low_cnt + e0, 0);
        chk("no_echo_uart_tx", uart_tx, 1'b1);
`endif
        chk("never_both_pulses", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
